mem_access: RTL and testbench

MEM-stage load/store unit of the 5-stage MIPS pipeline: takes the memory controls, ALU address, store data and instruction held in the EX/MEM register, runs a single-outstanding request/response transaction on the data-memory bus, and produces the aligned, extended load data that the MEM/WB register carries into writeback. It stalls the pipeline for the duration of each access and reports misaligned addresses instead of issuing them.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/load_store_align.sv | 69 ++++++
 rtl/mem_access.sv | 130 +++++++++++++
 tb/tb_mem_access.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, FSM states and access sizes for the MEM stage
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [31:0] NOP = 32'h0000_0020;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RESP  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_e;

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - opcode/offset decode, store lane steering and load extraction
module load_store_align
  import mips_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        misaligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  size_e      size;
  logic       sext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    size = WORD;
    sext = 1'b0;
    case (opcode_i)
      OP_LB:         begin size = BYTE; sext = 1'b1; end
      OP_LBU, OP_SB: size = BYTE;
      OP_LH:         begin size = HALF; sext = 1'b1; end
      OP_LHU, OP_SH: size = HALF;
      default:       size = WORD;
    endcase
  end

  assign misaligned_o = ((size == HALF) && off_i[0]) || ((size == WORD) && (off_i != 2'b00));

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (size)
      BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      HALF: begin
        be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

  // little-endian lanes: byte n of the word sits at rdata[8n+7:8n]
  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size)
      BYTE:    rdata_o = {{24{sext & byte_sel[7]}}, byte_sel};
      HALF:    rdata_o = {{16{sext & half_sel[15]}}, half_sel};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage load/store unit with single-outstanding data-memory bus
module mem_access
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              MEM_memread,
  input  logic              MEM_memwrite,
  input  logic [31:0]       MEM_alu_result,
  input  logic [31:0]       MEM_wdata,
  input  logic [31:0]       MEM_inst,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_stall,
  output logic [31:0]       MEM_memdata,
  output logic              mem_adel,
  output logic              mem_ades
);

  state_e            state_q;
  logic              req_q, we_q, load_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, memdata_q;
  logic [5:0]        opc_q;
  logic [1:0]        off_q;

  logic        idle, is_op, is_store, misaligned, launch;
  logic [5:0]  opc_sel;
  logic [1:0]  off_sel;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_c;
  logic        unused_inst;

  assign unused_inst = ^MEM_inst[25:0];

  assign idle     = (state_q == IDLE);
  assign is_op    = MEM_memread | MEM_memwrite;
  assign is_store = MEM_memwrite & ~MEM_memread;

  // once the access is in flight, decode from the captured opcode/offset
  assign opc_sel = idle ? MEM_inst[31:26] : opc_q;
  assign off_sel = idle ? MEM_alu_result[1:0] : off_q;

  load_store_align u_align (
    .opcode_i     (opc_sel),
    .off_i        (off_sel),
    .wdata_i      (MEM_wdata),
    .rdata_i      (dmem_rdata),
    .misaligned_o (misaligned),
    .be_o         (be_c),
    .wdata_o      (wdata_c),
    .rdata_o      (load_c)
  );

  assign launch = idle & is_op & ~misaligned & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'b0000;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      memdata_q <= 32'h0;
      opc_q     <= 6'h0;
      off_q     <= 2'b00;
      load_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            we_q    <= is_store;
            be_q    <= be_c;
            addr_q  <= {MEM_alu_result[ADDR_W-1:2], 2'b00};
            wdata_q <= is_store ? wdata_c : 32'h0;
            opc_q   <= MEM_inst[31:26];
            off_q   <= MEM_alu_result[1:0];
            load_q  <= MEM_memread;
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            req_q   <= 1'b0;
            state_q <= flush ? DRAIN : RESP;
          end else if (flush) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        RESP: begin
          if (flush) begin
            state_q <= dmem_rvalid ? IDLE : DRAIN;
          end else if (dmem_rvalid) begin
            state_q <= DONE;
            if (load_q) memdata_q <= load_c;
          end
        end
        DRAIN: begin
          if (dmem_rvalid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_be     = be_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign MEM_memdata = memdata_q;

  assign mem_stall = launch | (state_q == REQ) | (state_q == RESP) | (state_q == DRAIN);
  assign mem_adel  = idle & is_op & misaligned & ~flush & MEM_memread;
  assign mem_ades  = idle & is_op & misaligned & ~flush & is_store;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, memread, memwrite;
  logic [31:0] alu, wd, inst;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        dmem_req, dmem_we, mem_stall, mem_adel, mem_ades;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, memdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .MEM_memread    (memread),
    .MEM_memwrite   (memwrite),
    .MEM_alu_result (alu),
    .MEM_wdata      (wd),
    .MEM_inst       (inst),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_be        (dmem_be),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_gnt       (gnt),
    .dmem_rvalid    (rvalid),
    .dmem_rdata     (rdata),
    .mem_stall      (mem_stall),
    .MEM_memdata    (memdata),
    .mem_adel       (mem_adel),
    .mem_ades       (mem_ades)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op and acts as the memory slave; returns when the DONE cycle has been observed.
  task automatic do_access(input logic rd, input logic wr, input logic [5:0] opc,
                           input logic [31:0] addr, input logic [31:0] wdv, input logic [31:0] rdv,
                           input int gd, input int rdd,
                           output int stalls, output logic [3:0] be_s, output logic [31:0] addr_s,
                           output logic [31:0] wd_s, output logic we_s, output int unstable);
    int gc, rc, cyc;
    bit granted, rv_prev, done, seen;
    stalls = 0; unstable = 0; gc = 0; rc = 0; cyc = 0;
    granted = 0; rv_prev = 0; done = 0; seen = 0;
    be_s = 4'h0; addr_s = 32'h0; wd_s = 32'h0; we_s = 1'b0;
    memread = rd; memwrite = wr; alu = addr; wd = wdv; inst = {opc, 26'h0};
    while (!done && cyc < 60) begin
      gnt = 1'b0; rvalid = 1'b0;
      if (dmem_req && !granted) begin
        if (!seen) begin
          seen = 1; be_s = dmem_be; addr_s = dmem_addr; wd_s = dmem_wdata; we_s = dmem_we;
        end else if (dmem_be !== be_s || dmem_addr !== addr_s || dmem_wdata !== wd_s || dmem_we !== we_s) begin
          unstable++;
        end
        if (gc == gd) begin gnt = 1'b1; granted = 1; end
        else gc++;
      end else if (granted && !rv_prev) begin
        if (rc == rdd) begin rvalid = 1'b1; rdata = rdv; end
        else rc++;
      end
      #1;
      if (mem_stall) stalls++;
      if (rv_prev) done = 1;
      if (rvalid) rv_prev = 1;
      cyc++;
      step();
    end
    memread = 1'b0; memwrite = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    chk("access_completes", {31'h0, done}, 32'h1);
  endtask

  task automatic misalign(input string tag, input logic rd, input logic wr, input logic [5:0] opc,
                          input logic [31:0] addr, input logic exp_adel, input logic exp_ades);
    memread = rd; memwrite = wr; alu = addr; inst = {opc, 26'h0}; wd = 32'hFFFF_FFFF;
    #1;
    chk({tag, "_adel"}, {31'h0, mem_adel}, {31'h0, exp_adel});
    chk({tag, "_ades"}, {31'h0, mem_ades}, {31'h0, exp_ades});
    chk({tag, "_stall"}, {31'h0, mem_stall}, 32'h0);
    step();
    memread = 1'b0; memwrite = 1'b0;
    #1;
    chk({tag, "_noreq"}, {31'h0, dmem_req}, 32'h0);
    step();
  endtask

  typedef struct {
    string       tag;
    logic [5:0]  opc;
    logic [31:0] addr;
    logic [31:0] exp;
  } ld_vec_t;

  initial begin
    int st, uns;
    logic [3:0] be_s;
    logic [31:0] a_s, w_s;
    logic we_s;
    ld_vec_t lv [6];

    rst = 1'b1; flush = 1'b0; memread = 1'b0; memwrite = 1'b0;
    alu = 32'h0; wd = 32'h0; inst = NOP; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    step(); step();
    chk("rst_req",   {31'h0, dmem_req},  32'h0);
    chk("rst_we",    {31'h0, dmem_we},   32'h0);
    chk("rst_be",    {28'h0, dmem_be},   32'h0);
    chk("rst_addr",  dmem_addr,          32'h0);
    chk("rst_wdata", dmem_wdata,         32'h0);
    chk("rst_mdata", memdata,            32'h0);
    chk("rst_stall", {31'h0, mem_stall}, 32'h0);
    chk("rst_adel",  {31'h0, mem_adel},  32'h0);
    chk("rst_ades",  {31'h0, mem_ades},  32'h0);
    rst = 1'b0;
    step();

    do_access(1'b1, 1'b0, OP_LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, st, be_s, a_s, w_s, we_s, uns);
    chk("lw_data",  memdata, 32'hDEAD_BEEF);
    chk("lw_stall", st, 32'd3);
    chk("lw_be",    {28'h0, be_s}, 32'hF);
    chk("lw_addr",  a_s, 32'h100);
    chk("lw_we",    {31'h0, we_s}, 32'h0);

    lv[0] = '{"lb_103",  OP_LB,  32'h103, 32'hFFFF_FF80};
    lv[1] = '{"lbu_103", OP_LBU, 32'h103, 32'h0000_0080};
    lv[2] = '{"lh_102",  OP_LH,  32'h102, 32'hFFFF_80AA};
    lv[3] = '{"lhu_100", OP_LHU, 32'h100, 32'h0000_BBCC};
    lv[4] = '{"lb_101",  OP_LB,  32'h101, 32'hFFFF_FFBB};
    lv[5] = '{"lbu_100", OP_LBU, 32'h100, 32'h0000_00CC};
    for (int i = 0; i < 6; i++) begin
      do_access(1'b1, 1'b0, lv[i].opc, lv[i].addr, 32'h0, 32'h80AA_BBCC, 0, 0, st, be_s, a_s, w_s, we_s, uns);
      chk(lv[i].tag, memdata, lv[i].exp);
    end

    do_access(1'b0, 1'b1, OP_SH, 32'h0A, 32'h0000_1234, 32'h0, 0, 0, st, be_s, a_s, w_s, we_s, uns);
    chk("sh_be",    {28'h0, be_s}, 32'hC);
    chk("sh_wdata", w_s, 32'h1234_1234);
    chk("sh_addr",  a_s, 32'h08);
    chk("sh_we",    {31'h0, we_s}, 32'h1);
    chk("sh_mdata", memdata, 32'h0000_00CC);
    chk("sh_stall", st, 32'd3);

    do_access(1'b0, 1'b1, OP_SB, 32'h05, 32'h0000_00AB, 32'h0, 0, 0, st, be_s, a_s, w_s, we_s, uns);
    chk("sb_be",    {28'h0, be_s}, 32'h2);
    chk("sb_wdata", w_s, 32'hABAB_ABAB);
    chk("sb_addr",  a_s, 32'h04);

    misalign("lw_101", 1'b1, 1'b0, OP_LW, 32'h101, 1'b1, 1'b0);
    misalign("sw_102", 1'b0, 1'b1, OP_SW, 32'h102, 1'b0, 1'b1);
    misalign("lh_101", 1'b1, 1'b0, OP_LH, 32'h101, 1'b1, 1'b0);

    do_access(1'b1, 1'b0, OP_LW, 32'h300, 32'h0, 32'h1234_5678, 3, 2, st, be_s, a_s, w_s, we_s, uns);
    chk("slow_stall",  st, 32'd8);
    chk("slow_stable", uns, 32'd0);
    chk("slow_addr",   a_s, 32'h300);
    chk("slow_data",   memdata, 32'h1234_5678);

    // flush while waiting for the response: the late rvalid must be drained and discarded
    memread = 1'b1; inst = {OP_LW, 26'h0}; alu = 32'h200;
    #1; chk("fl_idle_stall", {31'h0, mem_stall}, 32'h1);
    step();
    chk("fl_req", {31'h0, dmem_req}, 32'h1);
    gnt = 1'b1;
    step();
    gnt = 1'b0; flush = 1'b1;
    #1; chk("fl_resp_stall", {31'h0, mem_stall}, 32'h1);
    step();
    flush = 1'b0; memread = 1'b0;
    #1;
    chk("fl_drain_stall", {31'h0, mem_stall}, 32'h1);
    chk("fl_drain_noreq", {31'h0, dmem_req}, 32'h0);
    step();
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    #1;
    chk("fl_drain2_stall", {31'h0, mem_stall}, 32'h1);
    chk("fl_drain2_noreq", {31'h0, dmem_req}, 32'h0);
    step();
    rvalid = 1'b0;
    #1;
    chk("fl_idle_after", {31'h0, mem_stall}, 32'h0);
    chk("fl_mdata", memdata, 32'h1234_5678);
    step();

    // reset while a store request is waiting for grant
    memwrite = 1'b1; inst = {OP_SW, 26'h0}; alu = 32'h40; wd = 32'h55;
    step();
    chk("rr_req", {31'h0, dmem_req}, 32'h1);
    rst = 1'b1; memwrite = 1'b0;
    step();
    chk("rr_req0",   {31'h0, dmem_req},  32'h0);
    chk("rr_we0",    {31'h0, dmem_we},   32'h0);
    chk("rr_be0",    {28'h0, dmem_be},   32'h0);
    chk("rr_addr0",  dmem_addr,          32'h0);
    chk("rr_wdata0", dmem_wdata,         32'h0);
    chk("rr_mdata0", memdata,            32'h0);
    chk("rr_stall0", {31'h0, mem_stall}, 32'h0);
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
